// File: rtl/match_scan_scheduler_if.sv
// match_scan_scheduler_if
// Bundles the command inputs and the match-memory / playback outputs of
// match_scan_scheduler.
//   master : drives i_* (entry controller / testbench), observes o_*
//   slave  : the scheduler itself
// Signals:
//   i_start       level, entry finished; scan and playback run while high
//   i_roll_back   pulse, restart playback at match 0
//   i_bit_count   number of entered string bits (4 per digit)
//   i_string      digit i at [4*MAX_DIGITS-1-4i -: 4]
//   i_comp        digit searched for
//   o_wr_en/o_wr_addr/o_wr_data  match memory write port
//   o_rd_addr     match memory read address during playback
//   o_match_count number of matches found by the last scan
//   o_scan_done   high in PLAY and DONE
//   o_blink       1 s on / 1 s off indicator during playback
//   o_busy        high in SCAN and PLAY
interface match_scan_scheduler_if #(
  parameter int unsigned MAX_DIGITS = 10
);
  logic                    i_start;
  logic                    i_roll_back;
  logic [7:0]              i_bit_count;
  logic [4*MAX_DIGITS-1:0] i_string;
  logic [3:0]              i_comp;
  logic                    o_wr_en;
  logic [5:0]              o_wr_addr;
  logic [7:0]              o_wr_data;
  logic [5:0]              o_rd_addr;
  logic [5:0]              o_match_count;
  logic                    o_scan_done;
  logic                    o_blink;
  logic                    o_busy;

  modport master (
    output i_start, i_roll_back, i_bit_count, i_string, i_comp,
    input  o_wr_en, o_wr_addr, o_wr_data, o_rd_addr, o_match_count,
    input  o_scan_done, o_blink, o_busy
  );

  modport slave (
    input  i_start, i_roll_back, i_bit_count, i_string, i_comp,
    output o_wr_en, o_wr_addr, o_wr_data, o_rd_addr, o_match_count,
    output o_scan_done, o_blink, o_busy
  );
endinterface

// File: rtl/match_scan_scheduler.sv
// match_scan_scheduler
// Scans an entered digit string for a target digit, one digit per cycle, writing the
// 1-based position of every hit into a match memory. Afterwards it plays the matches
// back one per blink period (FREQUENCY cycles on, FREQUENCY cycles off).
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high
//   bus    match_scan_scheduler_if.slave (see interface file for signal list)
// Parameters:
//   FREQUENCY   clk cycles per blink half-period
//   MAX_DIGITS  maximum number of stored digits
// Configuration macro:
//   MATCH_SCAN_WRAP_EN  defined: playback wraps to match 0 and loops forever;
//                       undefined: playback stops in DONE after the last match.
module match_scan_scheduler #(
  parameter int unsigned FREQUENCY  = 100_000_000,
  parameter int unsigned MAX_DIGITS = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  match_scan_scheduler_if.slave   bus
);

  localparam int unsigned IdxW  = $clog2(MAX_DIGITS + 1);
  localparam int unsigned TickW = $clog2(2 * FREQUENCY);

  typedef enum logic [1:0] {StIdle, StScan, StPlay, StDone} state_e;

  state_e           r_state, w_state_next;
  logic [IdxW-1:0]  r_num, w_num_next;
  logic [IdxW-1:0]  r_idx, w_idx_next;
  logic [5:0]       r_match_count, w_match_count_next;
  logic [5:0]       r_rd_addr, w_rd_addr_next;
  logic [TickW-1:0] r_tick, w_tick_next;
  logic             r_blink, r_scan_done, r_busy;
  logic             w_blink_next, w_scan_done_next, w_busy_next;

  logic [7:0]       w_bc_digits;
  logic [IdxW-1:0]  w_num_in;
  logic [3:0]       w_digit;
  logic             w_match;
  logic             w_scan_last;
  logic             w_play_last;
  logic             w_tick_wrap;

  // Digit count is clamped before narrowing so large bit counts cannot alias.
  assign w_bc_digits = bus.i_bit_count >> 2;
  assign w_num_in    = (32'(w_bc_digits) > MAX_DIGITS) ? IdxW'(MAX_DIGITS)
                                                       : IdxW'(w_bc_digits);

  always_comb begin
    w_digit = '0;
    for (int i = 0; i < int'(MAX_DIGITS); i++) begin
      if (r_idx == IdxW'(i)) begin
        w_digit = bus.i_string[4*(int'(MAX_DIGITS)-1-i) +: 4];
      end
    end
  end

  // r_idx < r_num keeps the single N=0 scan cycle write-free.
  assign w_match     = (r_state == StScan) && (r_idx < r_num) && (w_digit == bus.i_comp);
  assign w_scan_last = (r_num == '0) || (r_idx == r_num - IdxW'(1));
  assign w_play_last = (r_rd_addr == r_match_count - 6'd1);
  assign w_tick_wrap = (r_tick == TickW'(2 * FREQUENCY - 1));

  always_comb begin
    w_state_next       = r_state;
    w_num_next         = r_num;
    w_idx_next         = r_idx;
    w_match_count_next = r_match_count;
    // rd_addr and tick rest at zero unless PLAY explicitly keeps them.
    w_rd_addr_next     = '0;
    w_tick_next        = '0;

    // A write always bumps the count, so memory and count agree even on an abort.
    if (w_match) begin
      w_match_count_next = r_match_count + 6'd1;
    end

    if (!bus.i_start) begin
      w_state_next = StIdle;
      w_idx_next   = '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          w_state_next       = StScan;
          w_num_next         = w_num_in;
          w_idx_next         = '0;
          w_match_count_next = '0;
        end
        StScan: begin
          w_idx_next = r_idx + IdxW'(1);
          if (w_scan_last) begin
            w_idx_next   = '0;
            w_state_next = (w_match_count_next != '0) ? StPlay : StDone;
          end
        end
        StPlay: begin
          if (bus.i_roll_back) begin
            w_state_next = StPlay;
          end else if (w_tick_wrap) begin
            if (!w_play_last) begin
              w_rd_addr_next = r_rd_addr + 6'd1;
            end else begin
`ifdef MATCH_SCAN_WRAP_EN
              w_state_next = StPlay;
`else
              w_state_next = StDone;
`endif
            end
          end else begin
            w_rd_addr_next = r_rd_addr;
            w_tick_next    = r_tick + TickW'(1);
          end
        end
        StDone: begin
          if (bus.i_roll_back && (r_match_count != '0)) begin
            w_state_next = StPlay;
          end
        end
        default: w_state_next = StIdle;
      endcase
    end

    w_blink_next     = (w_state_next == StPlay) && (w_tick_next < TickW'(FREQUENCY));
    w_scan_done_next = (w_state_next == StPlay) || (w_state_next == StDone);
    w_busy_next      = (w_state_next == StScan) || (w_state_next == StPlay);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= StIdle;
      r_num         <= '0;
      r_idx         <= '0;
      r_match_count <= '0;
      r_rd_addr     <= '0;
      r_tick        <= '0;
      r_blink       <= 1'b0;
      r_scan_done   <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_num         <= w_num_next;
      r_idx         <= w_idx_next;
      r_match_count <= w_match_count_next;
      r_rd_addr     <= w_rd_addr_next;
      r_tick        <= w_tick_next;
      r_blink       <= w_blink_next;
      r_scan_done   <= w_scan_done_next;
      r_busy        <= w_busy_next;
    end
  end

  // Write port is gated so it reads all-zero whenever no write is happening.
  assign bus.o_wr_en         = w_match;
  assign bus.o_wr_addr       = w_match ? r_match_count : 6'd0;
  assign bus.o_wr_data       = w_match ? (8'(r_idx) + 8'd1) : 8'd0;
  assign bus.o_rd_addr       = r_rd_addr;
  assign bus.o_match_count   = r_match_count;
  assign bus.o_scan_done     = r_scan_done;
  assign bus.o_blink         = r_blink;
  assign bus.o_busy          = r_busy;

endmodule

// File: tb/tb_match_scan_scheduler.sv
// tb_match_scan_scheduler
// Directed, self-checking bench for match_scan_scheduler with FREQUENCY=4, MAX_DIGITS=10.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_match_scan_scheduler;

  localparam int unsigned Freq      = 4;
  localparam int unsigned MaxDigits = 10;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  match_scan_scheduler_if #(.MAX_DIGITS(MaxDigits)) bus ();

  match_scan_scheduler #(
    .FREQUENCY (Freq),
    .MAX_DIGITS(MaxDigits)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.i_start     = 1'b0;
    bus.i_roll_back = 1'b0;
    bus.i_bit_count = 8'd0;
    bus.i_string    = '0;
    bus.i_comp      = 4'd0;
    reset           = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.o_wr_en, bus.o_scan_done, bus.o_blink, bus.o_busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0000",
               {bus.o_wr_en, bus.o_scan_done, bus.o_blink, bus.o_busy});
    end
    checks++;
    if ({bus.o_match_count, bus.o_rd_addr} !== 12'd0) begin
      errors++;
      $display("FAIL reset_counts: match_count=%0d rd_addr=%0d want 0,0",
               bus.o_match_count, bus.o_rd_addr);
    end
    reset = 1'b0;
  endtask

  // Digits 3,5,3,0,3 searched for 3: hits on scan cycles 0,2,4.
  task automatic test_scan_basic();
    logic       exp_we   [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [5:0] exp_addr [5] = '{6'd0, 6'd0, 6'd1, 6'd0, 6'd2};
    logic [7:0] exp_data [5] = '{8'd1, 8'd0, 8'd3, 8'd0, 8'd5};
    bus.i_string    = 40'h35303_00000;
    bus.i_bit_count = 8'd20;
    bus.i_comp      = 4'd3;
    bus.i_start     = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      checks++;
      if ({bus.o_busy, bus.o_scan_done} !== 2'b10) begin
        errors++;
        $display("FAIL scan_busy[%0d]: got busy=%b done=%b want 1,0", k, bus.o_busy,
                 bus.o_scan_done);
      end
      checks++;
      if (bus.o_wr_en !== exp_we[k]) begin
        errors++;
        $display("FAIL scan_wr_en[%0d]: got %b want %b", k, bus.o_wr_en, exp_we[k]);
      end
      if (exp_we[k]) begin
        checks++;
        if ({bus.o_wr_addr, bus.o_wr_data} !== {exp_addr[k], exp_data[k]}) begin
          errors++;
          $display("FAIL scan_write[%0d]: got addr=%0d data=%0d want addr=%0d data=%0d", k,
                   bus.o_wr_addr, bus.o_wr_data, exp_addr[k], exp_data[k]);
        end
      end
    end
    cyc();
    checks++;
    if ({bus.o_scan_done, bus.o_busy, bus.o_blink, bus.o_wr_en} !== 4'b1110) begin
      errors++;
      $display("FAIL scan_end_flags: got done/busy/blink/wr_en=%b want 1110",
               {bus.o_scan_done, bus.o_busy, bus.o_blink, bus.o_wr_en});
    end
    checks++;
    if (bus.o_match_count !== 6'd3) begin
      errors++;
      $display("FAIL scan_match_count: got %0d want 3", bus.o_match_count);
    end
    bus.i_start = 1'b0;
    cyc();
    checks++;
    if ({bus.o_scan_done, bus.o_busy, bus.o_blink, bus.o_rd_addr} !== 9'd0) begin
      errors++;
      $display("FAIL idle_after_stop: got done=%b busy=%b blink=%b rd_addr=%0d want all 0",
               bus.o_scan_done, bus.o_busy, bus.o_blink, bus.o_rd_addr);
    end
    checks++;
    if (bus.o_match_count !== 6'd3) begin
      errors++;
      $display("FAIL idle_hold_count: got %0d want 3", bus.o_match_count);
    end
  endtask

  // bit_count=0: a single write-free scan cycle, then DONE with nothing to play.
  task automatic test_empty();
    bus.i_string    = 40'h33333_33333;
    bus.i_bit_count = 8'd0;
    bus.i_comp      = 4'd3;
    bus.i_start     = 1'b1;
    cyc();
    checks++;
    if ({bus.o_busy, bus.o_wr_en} !== 2'b10) begin
      errors++;
      $display("FAIL empty_scan: got busy=%b wr_en=%b want 1,0", bus.o_busy, bus.o_wr_en);
    end
    cyc();
    checks++;
    if ({bus.o_scan_done, bus.o_busy, bus.o_blink, bus.o_match_count} !== {3'b100, 6'd0})
    begin
      errors++;
      $display("FAIL empty_done: got done=%b busy=%b blink=%b count=%0d want 1,0,0,0",
               bus.o_scan_done, bus.o_busy, bus.o_blink, bus.o_match_count);
    end
    // roll_back must not start playback with no matches.
    bus.i_roll_back = 1'b1;
    cyc();
    bus.i_roll_back = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      checks++;
      if ({bus.o_blink, bus.o_busy, bus.o_scan_done} !== 3'b001) begin
        errors++;
        $display("FAIL empty_hold[%0d]: got blink=%b busy=%b done=%b want 0,0,1", k,
                 bus.o_blink, bus.o_busy, bus.o_scan_done);
      end
    end
    bus.i_start = 1'b0;
    cyc();
  endtask

  task automatic start_two_matches();
    bus.i_string    = 40'h717_0000000;
    bus.i_bit_count = 8'd12;
    bus.i_comp      = 4'd7;
    bus.i_start     = 1'b1;
    repeat (3) cyc();
  endtask

  // Two matches: 4 on / 4 off per match, rd_addr 0 then 1.
  task automatic test_playback();
    start_two_matches();
    for (int p = 0; p < 16; p++) begin
      cyc();
      checks++;
      if ({bus.o_busy, bus.o_blink, bus.o_rd_addr} !==
          {1'b1, ((p % 8) < 4) ? 1'b1 : 1'b0, 6'(p / 8)}) begin
        errors++;
        $display("FAIL play[%0d]: got busy=%b blink=%b rd_addr=%0d want 1,%0d,%0d", p,
                 bus.o_busy, bus.o_blink, bus.o_rd_addr, ((p % 8) < 4), p / 8);
      end
    end
    cyc();
`ifdef MATCH_SCAN_WRAP_EN
    checks++;
    if ({bus.o_busy, bus.o_blink, bus.o_rd_addr} !== {2'b11, 6'd0}) begin
      errors++;
      $display("FAIL play_wrap: got busy=%b blink=%b rd_addr=%0d want 1,1,0", bus.o_busy,
               bus.o_blink, bus.o_rd_addr);
    end
`else
    checks++;
    if ({bus.o_busy, bus.o_scan_done, bus.o_blink, bus.o_rd_addr} !== {3'b010, 6'd0}) begin
      errors++;
      $display("FAIL play_end: got busy=%b done=%b blink=%b rd_addr=%0d want 0,1,0,0",
               bus.o_busy, bus.o_scan_done, bus.o_blink, bus.o_rd_addr);
    end
    checks++;
    if (bus.o_match_count !== 6'd2) begin
      errors++;
      $display("FAIL play_count: got %0d want 2", bus.o_match_count);
    end
`endif
    bus.i_start = 1'b0;
    cyc();
  endtask

  task automatic test_roll_back();
    start_two_matches();
    // PLAY cycle 14: rd_addr=1, tick count 6.
    repeat (15) cyc();
    checks++;
    if ({bus.o_rd_addr, bus.o_blink} !== {6'd1, 1'b0}) begin
      errors++;
      $display("FAIL roll_pre: got rd_addr=%0d blink=%b want 1,0", bus.o_rd_addr,
               bus.o_blink);
    end
    bus.i_roll_back = 1'b1;
    cyc();
    bus.i_roll_back = 1'b0;
    checks++;
    if ({bus.o_busy, bus.o_blink, bus.o_rd_addr} !== {2'b11, 6'd0}) begin
      errors++;
      $display("FAIL roll_restart: got busy=%b blink=%b rd_addr=%0d want 1,1,0", bus.o_busy,
               bus.o_blink, bus.o_rd_addr);
    end
    // Tick restarted at 0: three more high cycles, then low.
    for (int q = 1; q <= 4; q++) begin
      cyc();
      checks++;
      if (bus.o_blink !== ((q < 4) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL roll_blink[%0d]: got %b want %0d", q, bus.o_blink, (q < 4));
      end
    end
`ifndef MATCH_SCAN_WRAP_EN
    repeat (12) cyc();
    checks++;
    if ({bus.o_busy, bus.o_scan_done} !== 2'b01) begin
      errors++;
      $display("FAIL roll_done: got busy=%b done=%b want 0,1", bus.o_busy, bus.o_scan_done);
    end
    bus.i_roll_back = 1'b1;
    cyc();
    bus.i_roll_back = 1'b0;
    checks++;
    if ({bus.o_busy, bus.o_blink, bus.o_rd_addr} !== {2'b11, 6'd0}) begin
      errors++;
      $display("FAIL roll_replay: got busy=%b blink=%b rd_addr=%0d want 1,1,0", bus.o_busy,
               bus.o_blink, bus.o_rd_addr);
    end
`endif
    // start=0 wins over a simultaneous roll_back.
    bus.i_roll_back = 1'b1;
    bus.i_start     = 1'b0;
    cyc();
    bus.i_roll_back = 1'b0;
    checks++;
    if ({bus.o_busy, bus.o_scan_done, bus.o_blink} !== 3'b000) begin
      errors++;
      $display("FAIL roll_priority: got busy=%b done=%b blink=%b want 0,0,0", bus.o_busy,
               bus.o_scan_done, bus.o_blink);
    end
  endtask

  // bit_count=200 clamps to 10 digits, every digit a hit.
  task automatic test_clamp();
    bus.i_string    = 40'hAAAA_AAAA_AA;
    bus.i_bit_count = 8'd200;
    bus.i_comp      = 4'hA;
    bus.i_start     = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc();
      checks++;
      if ({bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data} !== {1'b1, 6'(k), 8'(k + 1)}) begin
        errors++;
        $display("FAIL clamp_write[%0d]: got en=%b addr=%0d data=%0d want 1,%0d,%0d", k,
                 bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data, k, k + 1);
      end
    end
    cyc();
    checks++;
    if ({bus.o_match_count, bus.o_scan_done, bus.o_wr_en} !== {6'd10, 2'b10}) begin
      errors++;
      $display("FAIL clamp_end: got count=%0d done=%b wr_en=%b want 10,1,0",
               bus.o_match_count, bus.o_scan_done, bus.o_wr_en);
    end
    bus.i_start = 1'b0;
    cyc();
  endtask

  task automatic test_abort();
    bus.i_string    = 40'h2222_000000;
    bus.i_bit_count = 8'd16;
    bus.i_comp      = 4'd2;
    bus.i_start     = 1'b1;
    repeat (2) cyc();
    bus.i_start = 1'b0;
    cyc();
    checks++;
    if ({bus.o_busy, bus.o_scan_done, bus.o_wr_en} !== 3'b000) begin
      errors++;
      $display("FAIL abort_idle: got busy=%b done=%b wr_en=%b want 0,0,0", bus.o_busy,
               bus.o_scan_done, bus.o_wr_en);
    end
    checks++;
    if (bus.o_match_count == 6'd0 || bus.o_match_count > 6'd2) begin
      errors++;
      $display("FAIL abort_partial: got count=%0d want 1 or 2", bus.o_match_count);
    end
  endtask

  task automatic test_reset_mid_scan();
    bus.i_string    = 40'h2222_000000;
    bus.i_bit_count = 8'd16;
    bus.i_comp      = 4'd2;
    bus.i_start     = 1'b1;
    repeat (3) cyc();
    checks++;
    if ({bus.o_match_count, bus.o_wr_en} !== {6'd2, 1'b1}) begin
      errors++;
      $display("FAIL mid_pre: got count=%0d wr_en=%b want 2,1", bus.o_match_count,
               bus.o_wr_en);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.o_wr_en, bus.o_scan_done, bus.o_blink, bus.o_busy} !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset_flags: got %b want 0000",
               {bus.o_wr_en, bus.o_scan_done, bus.o_blink, bus.o_busy});
    end
    checks++;
    if ({bus.o_match_count, bus.o_rd_addr, bus.o_wr_addr, bus.o_wr_data} !== 26'd0) begin
      errors++;
      $display("FAIL mid_reset_values: got count=%0d rd=%0d waddr=%0d wdata=%0d want 0",
               bus.o_match_count, bus.o_rd_addr, bus.o_wr_addr, bus.o_wr_data);
    end
    bus.i_start = 1'b0;
    #2;
    reset = 1'b0;
    cyc();
    checks++;
    if (bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_idle: got busy=%b want 0", bus.o_busy);
    end
    bus.i_start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      checks++;
      if ({bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data} !== {1'b1, 6'(k), 8'(k + 1)}) begin
        errors++;
        $display("FAIL fresh_write[%0d]: got en=%b addr=%0d data=%0d want 1,%0d,%0d", k,
                 bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data, k, k + 1);
      end
    end
    cyc();
    checks++;
    if ({bus.o_match_count, bus.o_scan_done} !== {6'd4, 1'b1}) begin
      errors++;
      $display("FAIL fresh_end: got count=%0d done=%b want 4,1", bus.o_match_count,
               bus.o_scan_done);
    end
    bus.i_start = 1'b0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_scan_basic();
    test_empty();
    test_playback();
    test_roll_back();
    test_clamp();
    test_abort();
    test_reset_mid_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/match_scan_scheduler.md
MATCH_SCAN_SCHEDULER -- requirements
Module: match_scan_scheduler

Interface
REQ-001 The block SHALL have parameter FREQUENCY, default 100_000_000, giving the clk cycles per blink half-period (1 s).
REQ-002 The block SHALL have parameter MAX_DIGITS, default 10, giving the maximum number of stored 4-bit digits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: a level meaning entry is finished; scan and playback are permitted while it is high.
REQ-006 The block SHALL have port roll_back, input, 1 bit: an active-high pulse that restarts playback at match 0.
REQ-007 The block SHALL have port bit_count, input, 8 bits: the number of string bits entered, 4 per digit.
REQ-008 The block SHALL have port string, input, 4*MAX_DIGITS bits: digit i occupies bits [4*MAX_DIGITS-1-4i -: 4].
REQ-009 The block SHALL have port comp, input, 4 bits: the digit searched for.
REQ-010 The block SHALL have outputs wr_en (1 bit), wr_addr (6 bits) and wr_data (8 bits): the write port to the match memory.
REQ-011 The block SHALL have outputs rd_addr (6 bits), match_count (6 bits), scan_done (1 bit), blink (1 bit) and busy (1 bit).

Function
REQ-012 The block SHALL use the states IDLE, SCAN, PLAY and DONE.
- IDLE -> SCAN on start=1.
- SCAN -> PLAY after the last digit if match_count>0; otherwise SCAN -> DONE.
- PLAY and DONE -> IDLE on start=0.
REQ-013 The block SHALL compute the number of digits N = min(bit_count>>2, MAX_DIGITS) and latch N on entry to SCAN.
REQ-014 In SCAN the block SHALL examine digit i (i = 0..N-1) in the i-th SCAN cycle, one digit per cycle.
REQ-015 When string digit i equals comp, the block SHALL in that same cycle drive wr_en=1, wr_addr=match_count and wr_data=i+1, and SHALL increment match_count on the next edge.
REQ-016 When string digit i does not equal comp, the block SHALL hold wr_en=0.
REQ-017 With N=0, SCAN SHALL last one cycle with no writes, followed by DONE.
REQ-018 The block SHALL clear match_count on entry to SCAN and hold it otherwise; it SHALL never exceed MAX_DIGITS.
REQ-019 The block SHALL assert scan_done only in PLAY and DONE, so it rises the cycle after the final SCAN cycle.
REQ-020 In PLAY the tick counter SHALL count 0..2*FREQUENCY-1, with blink=1 for counts below FREQUENCY and blink=0 otherwise.
REQ-021 On tick counter wrap the block SHALL advance rd_addr by 1, or handle the last match per REQ-034/REQ-035.
REQ-022 The block SHALL hold rd_addr=0, blink=0 and the tick counter at 0 outside PLAY.
REQ-023 roll_back=1 in PLAY SHALL set rd_addr=0 and the tick counter to 0 on the next edge, so blink restarts high.
REQ-024 roll_back=1 in DONE with match_count>0 SHALL re-enter PLAY.
REQ-025 roll_back SHALL be ignored in IDLE and SCAN.
REQ-026 start falling in any state SHALL return the block to IDLE on the next edge and abort a SCAN in progress.
REQ-027 On a SCAN aborted by start falling, match_count SHALL keep its partial value.
REQ-028 If roll_back and start=0 occur in the same cycle, start=0 SHALL take priority.
REQ-029 The block SHALL assert busy=1 in SCAN and PLAY only.
REQ-030 All outputs SHALL be registered, except wr_en, wr_addr and wr_data, which are decoded combinationally from state and scan index.

Reset
REQ-031 On reset=1, asynchronously, the block SHALL set state=IDLE and clear match_count, rd_addr, the tick counter and the scan index.
REQ-032 On reset=1, asynchronously, the block SHALL drive wr_en=0, scan_done=0, blink=0 and busy=0.
REQ-033 Reset asserted mid-SCAN or mid-PLAY SHALL discard all progress; the memory contents are not cleared.

Configuration
REQ-034 With macro MATCH_SCAN_WRAP_EN defined, on tick wrap at rd_addr=match_count-1 the block SHALL set rd_addr=0 and continue PLAY indefinitely.
REQ-035 Without MATCH_SCAN_WRAP_EN, the same event SHALL move the block to DONE with blink=0 and rd_addr=0, leaving roll_back as the only way to replay.

Verification (FREQUENCY=4, MAX_DIGITS=10)
REQ-036 The bench SHALL cover: string digits 3,5,3,0,3 with bit_count=20 and comp=3, start=1 -> writes (addr0,data1), (addr1,data3), (addr2,data5) on SCAN cycles 0,2,4, and scan_done=1 with match_count=3 on the 6th cycle after start.
REQ-037 The bench SHALL cover: bit_count=0, start=1 -> one SCAN cycle, no wr_en, DONE with scan_done=1, match_count=0 and blink held 0.
REQ-038 The bench SHALL cover: playback with 2 matches -> blink high 4 cycles and low 4 cycles per match, rd_addr 0->1; then DONE without the macro, or rd_addr 0 and continued blinking with MATCH_SCAN_WRAP_EN.
REQ-039 The bench SHALL cover: roll_back pulse at rd_addr=1 with tick count 6 -> rd_addr=0, tick count=0 and blink=1 on the next edge.
REQ-040 The bench SHALL cover: bit_count=200 (N clamped to 10) with all digits equal to comp -> 10 writes, data 1..10, match_count=10.
REQ-041 The bench SHALL cover: reset pulse mid-SCAN after 2 matches -> all outputs 0 immediately, state IDLE, and a fresh scan on the next start.
